// File: rtl/sockit_spi_cdc_arb.sv
// rtl/sockit_spi_cdc_arb.sv - round-robin packet arbiter and clear sequencer for the CDC FIFO write port
// One owner at a time streams its packet straight through to the FIFO; clears only land between packets.
module sockit_spi_cdc_arb #(
    parameter int RN = 2,
    parameter int DW = 32,
    localparam int IW = (RN > 1) ? $clog2(RN) : 1
) (
    input  logic                 cdi_clk,
    input  logic                 cdi_rst,
    input  logic [RN*DW-1:0]     req_dat,
    input  logic [RN-1:0]        req_lst,
    input  logic [RN-1:0]        req_vld,
    output logic [RN-1:0]        req_rdy,
    input  logic                 flush,
    output logic                 flush_ack,
    output logic [RN-1:0]        gnt,
    output logic                 busy,
    output logic [IW+DW-1:0]     cdi_dat,
    output logic                 cdi_vld,
    input  logic                 cdi_rdy,
    output logic                 cdi_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RN-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            flush_pnd_q, flush_pnd_d;
    logic            cdi_clr_q, cdi_clr_d;
    logic            flush_ack_q, flush_ack_d;

    logic            found;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;
    logic            beat;

    // ptr holds the last winner, so the search starts one past it and wraps modulo RN.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= RN; k++) begin
            cand = IW'((int'(ptr_q) + k) % RN);
            if (!found && req_vld[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // While in BURST, ptr_q is the owner index.
    assign beat = (state_q == BURST) && req_vld[ptr_q] && cdi_rdy;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        flush_pnd_d = flush_pnd_q | flush;
        cdi_clr_d   = 1'b0;
        flush_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_pnd_q) begin
                    state_d     = FLUSH;
                    flush_pnd_d = flush;
                    cdi_clr_d   = 1'b1;
                    flush_ack_d = 1'b1;
                end else if (found) begin
                    state_d = BURST;
                    gnt_d   = {{(RN-1){1'b0}}, 1'b1} << sel;
                    ptr_d   = sel;
                end
            end
            BURST: begin
                if (beat && req_lst[ptr_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge cdi_clk or posedge cdi_rst) begin
        if (cdi_rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= IW'(RN - 1);
            flush_pnd_q <= 1'b0;
            cdi_clr_q   <= 1'b0;
            flush_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            flush_pnd_q <= flush_pnd_d;
            cdi_clr_q   <= cdi_clr_d;
            flush_ack_q <= flush_ack_d;
        end
    end

    assign gnt       = gnt_q;
    assign cdi_clr   = cdi_clr_q;
    assign flush_ack = flush_ack_q;
    assign busy      = (state_q != IDLE);
    assign cdi_vld   = (state_q == BURST) && req_vld[ptr_q];
    assign req_rdy   = (state_q == BURST) ? (gnt_q & {RN{cdi_rdy}}) : '0;
    assign cdi_dat   = {ptr_q, req_dat[int'(ptr_q)*DW +: DW]};

endmodule

// File: tb/tb_sockit_spi_cdc_arb.sv
// tb/tb_sockit_spi_cdc_arb.sv - directed self-checking bench for sockit_spi_cdc_arb
module tb_sockit_spi_cdc_arb;

    localparam int RN = 2;
    localparam int DW = 32;
    localparam int IW = 1;

    logic              cdi_clk = 1'b0;
    logic              cdi_rst;
    logic [RN*DW-1:0]  req_dat;
    logic [RN-1:0]     req_lst;
    logic [RN-1:0]     req_vld;
    logic [RN-1:0]     req_rdy;
    logic              flush;
    logic              flush_ack;
    logic [RN-1:0]     gnt;
    logic              busy;
    logic [IW+DW-1:0]  cdi_dat;
    logic              cdi_vld;
    logic              cdi_rdy;
    logic              cdi_clr;

    int checks = 0;
    int failures = 0;

    sockit_spi_cdc_arb #(.RN(RN), .DW(DW)) dut (
        .cdi_clk   (cdi_clk),
        .cdi_rst   (cdi_rst),
        .req_dat   (req_dat),
        .req_lst   (req_lst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .flush     (flush),
        .flush_ack (flush_ack),
        .gnt       (gnt),
        .busy      (busy),
        .cdi_dat   (cdi_dat),
        .cdi_vld   (cdi_vld),
        .cdi_rdy   (cdi_rdy),
        .cdi_clr   (cdi_clr)
    );

    always #5 cdi_clk = ~cdi_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cdi_clk);
        #1;
    endtask

    task automatic do_reset();
        cdi_rst = 1'b1;
        req_dat = '0;
        req_lst = '0;
        req_vld = '0;
        flush   = 1'b0;
        cdi_rdy = 1'b1;
        tick();
        tick();
        cdi_rst = 1'b0;
        #1;
    endtask

    logic [IW+DW-1:0] held;

    initial begin
        // reset state
        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", cdi_vld, 0);
        chk("rst_clr", cdi_clr, 0);
        chk("rst_ack", flush_ack, 0);
        chk("rst_rdy", req_rdy, 0);

        // 1: 3-word packet from requester 0
        req_vld = 2'b01;
        req_dat[31:0] = 32'hA000_0001;
        #1;
        chk("t1_idle_vld", cdi_vld, 0);
        tick();
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_w1_vld", cdi_vld, 1);
        chk("t1_w1_dat", cdi_dat, {1'b0, 32'hA000_0001});
        chk("t1_w1_rdy", req_rdy, 2'b01);
        tick();
        req_dat[31:0] = 32'hA000_0002;
        #1;
        chk("t1_w2_dat", cdi_dat, {1'b0, 32'hA000_0002});
        tick();
        req_dat[31:0] = 32'hA000_0003;
        req_lst = 2'b01;
        #1;
        chk("t1_w3_dat", cdi_dat, {1'b0, 32'hA000_0003});
        chk("t1_w3_busy", busy, 1);
        tick();
        req_vld = 2'b00;
        req_lst = 2'b00;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gnt", gnt, 0);

        // 2: both requesters send 1-word packets back to back
        do_reset();
        req_vld = 2'b11;
        req_lst = 2'b11;
        req_dat = {32'hBBBB_0001, 32'hAAAA_0000};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_id", cdi_dat[DW], (i % 2 == 0) ? 1'b0 : 1'b1);
            chk("t2_pay", cdi_dat[DW-1:0], (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
            tick();
            chk("t2_bubble_busy", busy, 0);
            chk("t2_bubble_vld", cdi_vld, 0);
        end

        // 3: FIFO stall mid-packet
        do_reset();
        req_vld = 2'b11;
        req_dat = {32'h1111_1111, 32'hC000_0001};
        tick();
        tick();
        req_dat[31:0] = 32'hC000_0002;
        cdi_rdy = 1'b0;
        #1;
        held = cdi_dat;
        chk("t3_held", held, {1'b0, 32'hC000_0002});
        for (int i = 0; i < 4; i++) begin
            chk("t3_vld", cdi_vld, 1);
            chk("t3_rdy", req_rdy, 0);
            chk("t3_dat", cdi_dat, held);
            chk("t3_gnt", gnt, 2'b01);
            tick();
        end
        cdi_rdy = 1'b1;
        req_lst = 2'b01;
        #1;
        chk("t3_resume_rdy", req_rdy, 2'b01);
        tick();
        req_lst = 2'b00;
        tick();
        chk("t3_next_gnt", gnt, 2'b10);

        // 4: flush pulse on word 2 of a 4-word packet
        do_reset();
        req_vld = 2'b01;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_w3_gnt", gnt, 2'b01);
        chk("t4_w3_clr", cdi_clr, 0);
        tick();
        req_lst = 2'b01;
        #1;
        chk("t4_w4_vld", cdi_vld, 1);
        tick();
        req_lst = 2'b00;
        chk("t4_idle_gnt", gnt, 0);
        chk("t4_idle_clr", cdi_clr, 0);
        tick();
        chk("t4_fl_clr", cdi_clr, 1);
        chk("t4_fl_ack", flush_ack, 1);
        chk("t4_fl_busy", busy, 1);
        chk("t4_fl_vld", cdi_vld, 0);
        chk("t4_fl_rdy", req_rdy, 0);
        chk("t4_fl_gnt", gnt, 0);
        tick();
        chk("t4_post_clr", cdi_clr, 0);
        chk("t4_post_ack", flush_ack, 0);
        chk("t4_post_gnt", gnt, 0);
        tick();
        chk("t4_regnt", gnt, 2'b01);

        // 5: owner drops valid mid-packet while requester 1 waits
        do_reset();
        req_vld = 2'b11;
        tick();
        chk("t5_gnt", gnt, 2'b01);
        tick();
        req_vld = 2'b10;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_gap_vld", cdi_vld, 0);
            chk("t5_gap_gnt", gnt, 2'b01);
            tick();
        end
        req_vld = 2'b11;
        req_lst = 2'b01;
        #1;
        chk("t5_back_vld", cdi_vld, 1);
        tick();
        req_lst = 2'b00;
        tick();
        chk("t5_next_gnt", gnt, 2'b10);

        // 6: asynchronous reset during BURST
        do_reset();
        req_vld = 2'b10;
        tick();
        chk("t6_gnt", gnt, 2'b10);
        #1;
        cdi_rst = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_vld", cdi_vld, 0);
        chk("t6_rst_clr", cdi_clr, 0);
        chk("t6_rst_busy", busy, 0);
        #1;
        cdi_rst = 1'b0;
        req_vld = 2'b11;
        tick();
        chk("t6_first_gnt", gnt, 2'b01);

        // 7: flush from IDLE, second pulse during FLUSH yields another clear
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t7_pend_clr", cdi_clr, 0);
        tick();
        chk("t7_clr1", cdi_clr, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t7_gap_clr", cdi_clr, 0);
        chk("t7_gap_busy", busy, 0);
        tick();
        chk("t7_clr2", cdi_clr, 1);
        chk("t7_ack2", flush_ack, 1);
        tick();
        chk("t7_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
